doodle_jump_fsm: RTL



---
 rtl/doodle_jump_fsm.sv | 174 +++++++++++++++++
 1 files changed

// File: rtl/doodle_jump_fsm.sv
// Vertical-motion sequencer for the doodle sprite: rise, hang, fall, die, with duty-cycled up/down requests.
// Optional build macro DOUBLE_JUMP_EN adds one mid-air jump per airborne phase.
module doodle_jump_fsm #(
  parameter int RISE_LOG2  = 6,
  parameter int HANG_TICKS = 4,
  parameter int FLOOR_Y    = 514
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        tick,
  input  logic        start,
  input  logic        land,
  input  logic        jump_btn,
  input  logic [9:0]  ypos,
  output logic        up,
  output logic        down,
  output logic [2:0]  state,
  output logic        game_over,
  output logic [15:0] bounce_count
);

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_RISE = 3'd1;
  localparam logic [2:0] S_APEX = 3'd2;
  localparam logic [2:0] S_FALL = 3'd3;
  localparam logic [2:0] S_DEAD = 3'd4;

  localparam int         FW        = RISE_LOG2 + 1;
  localparam logic [7:0] HANG_LAST = 8'(HANG_TICKS - 1);
  localparam logic [9:0] FLOOR     = 10'(FLOOR_Y);

  logic [RISE_LOG2-1:0] rc, rc_n;
  logic [7:0]           hc, hc_n;
  logic [FW-1:0]        fc, fc_n;
  logic [2:0]           state_n;
  logic [15:0]          bc_n;
  logic                 up_n, dn_n;
  logic                 start_pend, pend_eff;
  logic [1:0]           rseg, fseg;
  logic                 rise_up, fall_dn;
  logic                 jump_req;

  assign pend_eff  = start_pend | start;
  assign game_over = (state == S_DEAD);
  assign rseg      = rc[RISE_LOG2-1 -: 2];
  // fc's MSB alone marks saturation; the low two bits keep cycling past it
  assign fseg      = fc[FW-1] ? 2'd3 : fc[RISE_LOG2-1 -: 2];

`ifdef DOUBLE_JUMP_EN
  logic jump_prev, jump_lat, air_jump_used, jump_edge;

  assign jump_edge = jump_btn & ~jump_prev;
  assign jump_req  = (jump_lat | jump_edge) & ~air_jump_used;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      jump_prev     <= 1'b0;
      jump_lat      <= 1'b0;
      air_jump_used <= 1'b0;
    end else begin
      jump_prev <= jump_btn;
      if (tick)
        jump_lat <= 1'b0;
      else if (jump_edge)
        jump_lat <= 1'b1;
      if (tick && (((state == S_IDLE || state == S_DEAD) && pend_eff) ||
                   (state == S_FALL && land)))
        air_jump_used <= 1'b0;
      else if (tick && jump_req && (state == S_APEX || state == S_FALL))
        air_jump_used <= 1'b1;
    end
  end
`else
  logic unused_jump_btn;
  assign unused_jump_btn = jump_btn;
  assign jump_req        = 1'b0;
`endif

  always_comb begin
    case (rseg)
      2'd0:    rise_up = 1'b1;
      2'd1:    rise_up = (rc[1:0] != 2'd3);
      2'd2:    rise_up = ~rc[0];
      default: rise_up = (rc[1:0] == 2'd0);
    endcase
    case (fseg)
      2'd0:    fall_dn = (fc[1:0] == 2'd0);
      2'd1:    fall_dn = ~fc[0];
      2'd2:    fall_dn = (fc[1:0] != 2'd3);
      default: fall_dn = 1'b1;
    endcase
  end

  always_comb begin
    state_n = state;
    rc_n    = rc;
    hc_n    = hc;
    fc_n    = fc;
    bc_n    = bounce_count;
    up_n    = 1'b0;
    dn_n    = 1'b0;
    if (tick) begin
      case (state)
        S_IDLE, S_DEAD: begin
          if (pend_eff) begin
            state_n = S_RISE;
            rc_n    = '0;
            bc_n    = '0;
          end
        end
        S_RISE: begin
          up_n = rise_up;
          rc_n = rc + 1'b1;
          if (&rc) begin
            state_n = S_APEX;
            hc_n    = '0;
          end
        end
        S_APEX: begin
          if (jump_req) begin
            state_n = S_RISE;
            rc_n    = '0;
          end else if (hc == HANG_LAST) begin
            state_n = S_FALL;
            fc_n    = '0;
          end else begin
            hc_n = hc + 8'd1;
          end
        end
        S_FALL: begin
          // landing beats both the air jump and the floor on the same tick
          if (land) begin
            state_n = S_RISE;
            rc_n    = '0;
            if (bounce_count != 16'hFFFF)
              bc_n = bounce_count + 16'd1;
          end else if (jump_req) begin
            state_n = S_RISE;
            rc_n    = '0;
          end else if (ypos >= FLOOR) begin
            state_n = S_DEAD;
          end else begin
            dn_n = fall_dn;
            fc_n = fc[FW-1] ? {fc[FW-1:2], fc[1:0] + 2'd1} : fc + 1'b1;
          end
        end
        default: state_n = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= S_IDLE;
      rc           <= '0;
      hc           <= '0;
      fc           <= '0;
      bounce_count <= '0;
      up           <= 1'b0;
      down         <= 1'b0;
      start_pend   <= 1'b0;
    end else begin
      state        <= state_n;
      rc           <= rc_n;
      hc           <= hc_n;
      fc           <= fc_n;
      bounce_count <= bc_n;
      up           <= up_n;
      down         <= dn_n;
      start_pend   <= tick ? 1'b0 : pend_eff;
    end
  end

endmodule
